// File: rtl/q2_panel.sv
// Front-panel conditioner for the q2 core: synchronises and debounces the data switches and
// the four momentary keys, then turns accepted key presses into qualified one-clock pulses.
module q2_panel #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] raw_sw,
  input  logic        raw_incp,
  input  logic        raw_dep,
  input  logic        raw_start,
  input  logic        raw_stop,
  input  logic        run,
  output logic [11:0] sw,
  output logic        incp_sw,
  output logic        dep_sw,
  output logic        start_sw,
  output logic        stop_sw,
  output logic        sw_stable
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned NumSw = 12;
  localparam int unsigned NumCh = NumSw + 4;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Key indices within the 4-bit key slice (channels NumSw..NumSw+3).
  localparam int unsigned KeyIncp  = 0;
  localparam int unsigned KeyDep   = 1;
  localparam int unsigned KeyStart = 2;
  localparam int unsigned KeyStop  = 3;

  logic [NumCh-1:0] raw_vec;
  assign raw_vec = {raw_stop, raw_start, raw_dep, raw_incp, raw_sw};

  // Synchroniser chains; index SYNC_STAGES-1 is the last (metastability-safe) stage.
  logic [SYNC_STAGES-1:0][NumCh-1:0] sync_q;
  logic [NumCh-1:0]                  s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_vec};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce: a channel accepts a new level only after DEBOUNCE_CYCLES consecutive mismatches.
  logic [NumCh-1:0]            d_q, d_d;
  logic [NumCh-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    d_d   = d_q;
    cnt_d = cnt_q;
    for (int i = 0; i < int'(NumCh); i++) begin
      if (s[i] == d_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        d_d[i]   = s[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q   <= '0;
      cnt_q <= '0;
    end else begin
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end

  // Data word stability: every switch channel settled and no count in flight.
  logic [NumSw-1:0] sw_calm;
  logic             sw_stable_d, sw_stable_q;

  always_comb begin
    sw_calm = '0;
    for (int i = 0; i < int'(NumSw); i++) begin
      sw_calm[i] = (s[i] == d_q[i]) && (cnt_q[i] == '0);
    end
  end

  assign sw_stable_d = &sw_calm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_stable_q <= 1'b0;
    end else begin
      sw_stable_q <= sw_stable_d;
    end
  end

  // Key edges are taken from the debounced next state so the pulse register fires on the
  // same edge that accepts the press.
  logic [3:0] key_q, key_d, key_rise;
  logic [3:0] pulse_d, pulse_q;

  assign key_q    = d_q[NumCh-1:NumSw];
  assign key_d    = d_d[NumCh-1:NumSw];
  assign key_rise = key_d & ~key_q;

  // Priority STOP > START > DEP > INCP keeps the outputs mutually exclusive; losers are dropped.
  always_comb begin
    pulse_d = '0;
    if (key_rise[KeyStop]) begin
      pulse_d[KeyStop] = 1'b1;
    end else if (key_rise[KeyStart] && !run) begin
      pulse_d[KeyStart] = 1'b1;
    end else if (key_rise[KeyDep] && !run && sw_stable_q) begin
      pulse_d[KeyDep] = 1'b1;
    end else if (key_rise[KeyIncp] && !run && sw_stable_q) begin
      pulse_d[KeyIncp] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  assign sw        = d_q[NumSw-1:0];
  assign sw_stable = sw_stable_q;
  assign incp_sw   = pulse_q[KeyIncp];
  assign dep_sw    = pulse_q[KeyDep];
  assign start_sw  = pulse_q[KeyStart];
  assign stop_sw   = pulse_q[KeyStop];

endmodule

// File: tb/tb_q2_panel.sv
// Bench for q2_panel: directed panel scenarios plus random switch/key activity, all checked
// every clock against a behavioural model of the synchronise/debounce/qualify rules.
module tb_q2_panel;

  localparam int unsigned DEB  = 16;
  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] raw_sw = '0;
  logic        raw_incp = 1'b0, raw_dep = 1'b0, raw_start = 1'b0, raw_stop = 1'b0;
  logic        run = 1'b0;
  logic [11:0] sw;
  logic        incp_sw, dep_sw, start_sw, stop_sw, sw_stable;

  always #5 clk = ~clk;

  q2_panel #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .raw_sw   (raw_sw),
    .raw_incp (raw_incp),
    .raw_dep  (raw_dep),
    .raw_start(raw_start),
    .raw_stop (raw_stop),
    .run      (run),
    .sw       (sw),
    .incp_sw  (incp_sw),
    .dep_sw   (dep_sw),
    .start_sw (start_sw),
    .stop_sw  (stop_sw),
    .sw_stable(sw_stable)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_incp, n_dep, n_start, n_stop, n_unstable, stop_cyc, rel_cyc;

  // Model: sampled-raw history, accepted levels, mismatch streaks, stable flag, pulses.
  logic [15:0] m_hist [SYNC];
  logic [15:0] m_d;
  int          m_streak [16];
  logic        m_stable;
  logic [3:0]  m_pulse;

  function automatic logic [15:0] raw_now();
    return {raw_stop, raw_start, raw_dep, raw_incp, raw_sw};
  endfunction

  task automatic model_reset();
    for (int j = 0; j < int'(SYNC); j++) m_hist[j] = '0;
    for (int i = 0; i < 16; i++) m_streak[i] = 0;
    m_d      = '0;
    m_stable = 1'b0;
    m_pulse  = '0;
  endtask

  task automatic model_edge();
    logic [15:0] s, d_new;
    logic [3:0]  rise, p;
    logic        stab;
    if (!rst) begin
      model_reset();
      return;
    end
    s    = m_hist[SYNC-1];
    stab = 1'b1;
    for (int i = 0; i < 12; i++) if (s[i] != m_d[i] || m_streak[i] != 0) stab = 1'b0;
    d_new = m_d;
    for (int i = 0; i < 16; i++) begin
      if (s[i] == m_d[i]) m_streak[i] = 0;
      else if (m_streak[i] == int'(DEB) - 1) begin
        d_new[i] = s[i];
        m_streak[i] = 0;
      end else m_streak[i]++;
    end
    rise = d_new[15:12] & ~m_d[15:12];
    p    = '0;
    if (rise[3]) p = 4'b1000;
    else if (rise[2] && !run) p = 4'b0100;
    else if (rise[1] && !run && m_stable) p = 4'b0010;
    else if (rise[0] && !run && m_stable) p = 4'b0001;
    for (int j = int'(SYNC) - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = raw_now();
    m_d      = d_new;
    m_stable = stab;
    m_pulse  = p;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic zero_counts();
    n_incp = 0; n_dep = 0; n_start = 0; n_stop = 0; n_unstable = 0; stop_cyc = -1;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check("sw", {20'b0, sw}, {20'b0, m_d[11:0]});
    check("sw_stable", {31'b0, sw_stable}, {31'b0, m_stable});
    check("pulses", {28'b0, stop_sw, start_sw, dep_sw, incp_sw}, {28'b0, m_pulse});
    check("one_pulse_max", {31'b0, ($countones({stop_sw, start_sw, dep_sw, incp_sw}) <= 1)}, 1);
    if (incp_sw) n_incp++;
    if (dep_sw) n_dep++;
    if (start_sw) n_start++;
    if (stop_sw) begin
      n_stop++;
      stop_cyc = cyc;
    end
    if (!sw_stable) n_unstable++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {16'b0, sw, sw_stable, incp_sw, dep_sw, start_sw, stop_sw}, 32'b0);
  endtask

  initial begin
    model_reset();
    zero_counts();

    // Keys held through reset: only one stop pulse, SYNC+DEB clocks after release.
    raw_incp = 1'b1; raw_dep = 1'b1; raw_start = 1'b1; raw_stop = 1'b1;
    #1;
    check_reset_outputs("reset_outputs");
    repeat (3) step();
    check_reset_outputs("reset_outputs_clocked");
    rst = 1'b1;
    zero_counts();
    rel_cyc = cyc;
    repeat (30) step();
    check("rel_stop_count", n_stop, 1);
    check("rel_stop_latency", stop_cyc - rel_cyc, SYNC + DEB);
    check("rel_other_pulses", n_start + n_dep + n_incp, 0);
    raw_incp = 1'b0; raw_dep = 1'b0; raw_start = 1'b0; raw_stop = 1'b0;
    repeat (40) step();

    // START glitch rejected, long press gives one pulse, release gives none.
    zero_counts();
    raw_start = 1'b1;
    repeat (10) step();
    raw_start = 1'b0;
    repeat (30) step();
    check("start_glitch", n_start, 0);
    raw_start = 1'b1;
    repeat (40) step();
    check("start_held", n_start, 1);
    raw_start = 1'b0;
    repeat (40) step();
    check("start_release", n_start, 1);

    // Steady data word then DEP deposits exactly once.
    raw_sw = 12'o1234;
    repeat (30) step();
    check("sw_word", {20'b0, sw}, {20'b0, 12'o1234});
    check("sw_settled", {31'b0, sw_stable}, 1);
    zero_counts();
    raw_dep = 1'b1;
    repeat (40) step();
    check("dep_once", n_dep, 1);
    raw_dep = 1'b0;
    repeat (30) step();
    check("dep_release", n_dep, 1);

    // Running CPU blocks DEP/INCP but not STOP.
    run = 1'b1;
    zero_counts();
    raw_dep = 1'b1; raw_incp = 1'b1;
    repeat (40) step();
    check("run_blocks_mem", n_dep + n_incp, 0);
    raw_stop = 1'b1;
    repeat (40) step();
    check("run_stop", n_stop, 1);
    raw_dep = 1'b0; raw_incp = 1'b0; raw_stop = 1'b0;
    repeat (40) step();
    run = 1'b0;
    repeat (5) step();

    // START and STOP together: STOP wins.
    zero_counts();
    raw_start = 1'b1; raw_stop = 1'b1;
    repeat (40) step();
    check("both_stop", n_stop, 1);
    check("both_start", n_start, 0);
    raw_start = 1'b0; raw_stop = 1'b0;
    repeat (40) step();

    // Bouncing sw[5] while DEP pressed: word unsettled at the press, DEP dropped.
    zero_counts();
    for (int i = 0; i < 64; i++) begin
      if (i == 0) raw_dep = 1'b1;
      if (i % 4 == 2) raw_sw[5] = ~raw_sw[5];
      step();
    end
    check("bounce_dep", n_dep, 0);
    check("bounce_unstable_seen", {31'b0, (n_unstable != 0)}, 1);
    check("bounce_word", {20'b0, sw}, {20'b0, 12'o1234});
    raw_dep = 1'b0;
    repeat (40) step();

    // Reset mid-count with STOP held: count restarts from zero after release.
    raw_stop = 1'b1;
    repeat (8) step();
    rst = 1'b0;
    #1;
    check_reset_outputs("midop_reset_outputs");
    repeat (2) step();
    rst = 1'b1;
    zero_counts();
    rel_cyc = cyc;
    repeat (30) step();
    check("midop_stop_count", n_stop, 1);
    check("midop_stop_latency", stop_cyc - rel_cyc, SYNC + DEB);
    raw_stop = 1'b0;
    repeat (40) step();

    // Random activity: mean hold ~24 clocks mixes accepted changes and rejected glitches.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 12; b++) if ($urandom_range(0, 23) == 0) raw_sw[b] = ~raw_sw[b];
      if ($urandom_range(0, 23) == 0) raw_incp = ~raw_incp;
      if ($urandom_range(0, 23) == 0) raw_dep = ~raw_dep;
      if ($urandom_range(0, 23) == 0) raw_start = ~raw_start;
      if ($urandom_range(0, 23) == 0) raw_stop = ~raw_stop;
      if ($urandom_range(0, 59) == 0) run = ~run;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
